// File: rtl/ram_result_tx.sv
// Reads Word_count words from Data RAM and sends each as two 8N1 UART bytes, low byte first.
// Optional build macro RESULT_TX_CHECKSUM_EN appends a two's-complement checksum word.
module ram_result_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BIT_WIDTH    = 16,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_addr,
    input  logic [ADDR_WIDTH:0]   Word_count,
    output logic                  Rd_en,
    output logic [ADDR_WIDTH-1:0] Rd_addr,
    input  logic [BIT_WIDTH-1:0]  Rd_data,
    output logic                  o_Tx_Serial,
    output logic                  Busy,
    output logic                  Done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP, S_DONE
    } t_state;

    t_state                r_state;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH:0]   r_words_left;
    logic [BAUD_W-1:0]     r_baud;
    logic [3:0]            r_bit;
    logic                  r_byte_hi;
    logic [BIT_WIDTH-1:0]  r_shift;
    logic                  w_baud_end;
    logic [BIT_WIDTH-1:0]  w_load;

    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign o_Tx_Serial = r_tx;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Rd_en       = r_rd_en;
    assign Rd_addr     = r_rd_addr;

`ifdef RESULT_TX_CHECKSUM_EN
    logic                 r_trailer;
    logic [BIT_WIDTH-1:0] r_acc;
    logic [BIT_WIDTH-1:0] w_cks;

    assign w_cks  = ~r_acc + BIT_WIDTH'(1);
    assign w_load = r_trailer ? w_cks : Rd_data;

    always_ff @(posedge Clk) begin
        if (r_state == S_IDLE && Start)
            r_acc <= '0;
        else if (r_state == S_WAIT && !r_trailer)
            r_acc <= r_acc + Rd_data;
    end
`else
    assign w_load = Rd_data;
`endif

    // Word shift register: loaded in WAIT, shifted once per data bit sent.
    always_ff @(posedge Clk) begin
        if (r_state == S_WAIT)
            r_shift <= w_load;
        else if (w_baud_end && (r_state == S_START || (r_state == S_DATA && r_bit != 4'd8)))
            r_shift <= {1'b0, r_shift[BIT_WIDTH-1:1]};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_words_left <= '0;
            r_baud       <= '0;
            r_bit        <= '0;
            r_byte_hi    <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            r_trailer    <= 1'b0;
`endif
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_rd_addr    <= Base_addr;
                        r_words_left <= Word_count;
                        r_byte_hi    <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
                        // An empty request still sends the checksum word, so it never skips FETCH.
                        r_trailer    <= (Word_count == '0);
                        r_rd_en      <= (Word_count != '0);
                        r_busy       <= 1'b1;
                        r_state      <= S_FETCH;
`else
                        if (Word_count == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end
`endif
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    r_tx    <= 1'b0;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_bit   <= 4'd1;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 4'd8) begin
                            r_tx    <= 1'b1;
                            r_bit   <= 4'd9;
                            r_state <= S_STOP;
                        end else begin
                            r_tx  <= r_shift[0];
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        r_bit  <= '0;
                        if (!r_byte_hi) begin
                            r_byte_hi <= 1'b1;
                            r_tx      <= 1'b0;
                            r_state   <= S_START;
                        end else begin
                            r_byte_hi <= 1'b0;
                            if (r_words_left > (ADDR_WIDTH+1)'(1)) begin
                                r_words_left <= r_words_left - (ADDR_WIDTH+1)'(1);
                                r_rd_addr    <= r_rd_addr + ADDR_WIDTH'(1);
                                r_rd_en      <= 1'b1;
                                r_state      <= S_FETCH;
`ifdef RESULT_TX_CHECKSUM_EN
                            end else if (!r_trailer) begin
                                r_trailer    <= 1'b1;
                                r_words_left <= '0;
                                r_state      <= S_FETCH;
`endif
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DONE: begin
                    // An empty request arrives here with Done low and pulses it one cycle later.
                    if (r_done) r_state <= S_IDLE;
                    else        r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_result_tx.sv
// Randomized bench for ram_result_tx: cycle-accurate expectations built from the frame/word rules.
module tb_ram_result_tx;
    localparam int C  = 4;
    localparam int AW = 9;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Start = 1'b0;
    logic [AW-1:0] Base_addr = '0;
    logic [AW:0]   Word_count = '0;
    logic          Rd_en;
    logic [AW-1:0] Rd_addr;
    logic [15:0]   Rd_data;
    logic          o_Tx_Serial;
    logic          Busy;
    logic          Done;

    ram_result_tx #(.CLKS_PER_BIT(C), .BIT_WIDTH(16), .ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Base_addr(Base_addr),
        .Word_count(Word_count), .Rd_en(Rd_en), .Rd_addr(Rd_addr), .Rd_data(Rd_data),
        .o_Tx_Serial(o_Tx_Serial), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    logic [15:0]   ram [0:511];
    logic          r_vld = 1'b0;
    logic [AW-1:0] r_a = '0;
    logic [15:0]   r_junk = '0;

    always @(posedge Clk) begin
        r_vld  <= Rd_en;
        r_a    <= Rd_addr;
        r_junk <= 16'($urandom);
    end
    assign Rd_data = r_vld ? ram[r_a] : r_junk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    logic e_tx[$];
    logic e_busy[$];
    logic e_done[$];
    logic e_rden[$];
    int   e_addr[$];

    task automatic push(input logic tx, input logic bz, input logic dn, input logic re, input int ad);
        e_tx.push_back(tx);
        e_busy.push_back(bz);
        e_done.push_back(dn);
        e_rden.push_back(re);
        e_addr.push_back(ad);
    endtask

    task automatic build(input int base, input int count);
        logic [15:0] words[$];
        logic [15:0] sum;
        logic [7:0]  b;
        logic        lvl;
        e_tx.delete(); e_busy.delete(); e_done.delete(); e_rden.delete(); e_addr.delete();
        sum = '0;
        for (int j = 0; j < count; j++) begin
            words.push_back(ram[(base + j) % 512]);
            sum = sum + ram[(base + j) % 512];
        end
`ifdef RESULT_TX_CHECKSUM_EN
        words.push_back(16'd0 - sum);
`endif
        if (words.size() == 0) begin
            push(1'b1, 1'b0, 1'b0, 1'b0, 0);
            push(1'b1, 1'b0, 1'b1, 1'b0, 0);
            push(1'b1, 1'b0, 1'b0, 1'b0, 0);
        end else begin
            for (int j = 0; j < words.size(); j++) begin
                push(1'b1, 1'b1, 1'b0, (j < count), (base + j) % 512);
                push(1'b1, 1'b1, 1'b0, 1'b0, 0);
                for (int h = 0; h < 2; h++) begin
                    b = (h == 0) ? words[j][7:0] : words[j][15:8];
                    for (int p = 0; p < 10; p++) begin
                        lvl = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
                        for (int c = 0; c < C; c++) push(lvl, 1'b1, 1'b0, 1'b0, 0);
                    end
                end
            end
            push(1'b1, 1'b0, 1'b1, 1'b0, 0);
            push(1'b1, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    // inj: cycle index at which a stray Start is raised; rst: index at which reset hits (-1 = none).
    task automatic run(input int base, input int count, input int inj, input int rst);
        build(base, count);
        Base_addr  = AW'(base);
        Word_count = (AW+1)'(count);
        Start      = 1'b1;
        for (int i = 0; i < e_tx.size(); i++) begin
            @(posedge Clk);
            #1;
            Start = 1'b0;
            chk("tx", o_Tx_Serial, e_tx[i]);
            chk("busy", Busy, e_busy[i]);
            chk("done", Done, e_done[i]);
            chk("rd_en", Rd_en, e_rden[i]);
            if (e_rden[i]) chk("rd_addr", Rd_addr, e_addr[i]);
            if (i == inj) begin
                Start      = 1'b1;
                Base_addr  = AW'($urandom);
                Word_count = (AW+1)'($urandom_range(1, 5));
            end
            if (i == rst) begin
                #2 Rst_n = 1'b0;
                #1;
                chk("rst_tx", o_Tx_Serial, 1'b1);
                chk("rst_busy", Busy, 1'b0);
                chk("rst_done", Done, 1'b0);
                chk("rst_rd_en", Rd_en, 1'b0);
                repeat (2) @(negedge Clk);
                Rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 16'($urandom);
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_tx", o_Tx_Serial, 1'b1);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_done", Done, 1'b0);
        chk("reset_rd_en", Rd_en, 1'b0);
        chk("reset_rd_addr", Rd_addr, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        ram[0] = 16'h12A5;
        run(0, 1, -1, -1);
        ram[510] = 16'h0001; ram[511] = 16'h0002; ram[0] = 16'h0003;
        run(510, 3, -1, -1);
        run(5, 0, -1, -1);
        run(510, 3, 2 + 20*C + 2 + 5, -1);
        run(20, 2, -1, 2 + 10*C + C + 3*C);
        run(20, 2, -1, -1);
        ram[100] = 16'h0001; ram[101] = 16'h0002;
        run(100, 2, -1, -1);
        for (int t = 0; t < 8; t++) begin
            run(int'($urandom_range(0, 511)), int'($urandom_range(0, 6)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
